// File: rtl/inv_round_key_gen.sv
// Decrypt-side AES-128 key schedule: expands rx_key to the round-10 key, then walks round keys downward.
// Build option INV_KEY_CACHE_EN keeps all 11 round keys in a register array for registered lookup.
module inv_round_key_gen #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chg_key,
    input  logic [KEY_W-1:0] rx_key,
    input  logic [3:0]       cur_round,
    output logic [KEY_W-1:0] cur_key,
    output logic             key_valid,
    output logic [KEY_W-1:0] final_key,
    output logic [KEY_W-1:0] orig_key,
    output logic             change_key_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_READY, ST_RELOAD} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [3:0] PRE_LAST   = 4'(NR - 1);

    // Row-major AES S-box; entry 0 sits in the most significant byte.
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_k;
    logic [KEY_W-1:0] r_cur_key;
    logic [KEY_W-1:0] r_final_key;
    logic [KEY_W-1:0] r_orig_key;
    logic             r_done;

    logic             w_load;
    logic             w_fwd_step;
    logic             w_finish;
    logic [31:0]      w_w0, w_w1, w_w2, w_w3;
    logic [31:0]      w_sub_in;
    logic [7:0]       w_rcon;
    logic [31:0]      w_sub_out;
    logic [31:0]      w_f0, w_f1, w_f2, w_f3;
    logic [KEY_W-1:0] w_fwd_key;

`ifdef INV_KEY_CACHE_EN
    logic [KEY_W-1:0] r_cache [NR+1];
    logic             w_cache_rd;
`else
    logic             w_inv_step;
    logic             w_reload;
    logic [KEY_W-1:0] w_inv_key;
`endif

    assign {w_w0, w_w1, w_w2, w_w3} = r_cur_key;

    // One SubWord instance serves both directions; only its input word and Rcon index differ.
`ifdef INV_KEY_CACHE_EN
    assign w_sub_in = w_w3;
    assign w_rcon   = rcon(r_k + 4'd1);
`else
    assign w_sub_in = (r_state == ST_EXPAND) ? w_w3 : (w_w3 ^ w_w2);
    assign w_rcon   = rcon((r_state == ST_EXPAND) ? (r_k + 4'd1) : r_k);
`endif
    assign w_sub_out = sub_rot_word(w_sub_in) ^ {w_rcon, 24'h000000};

    assign w_f0      = w_w0 ^ w_sub_out;
    assign w_f1      = w_w1 ^ w_f0;
    assign w_f2      = w_w2 ^ w_f1;
    assign w_f3      = w_w3 ^ w_f2;
    assign w_fwd_key = {w_f0, w_f1, w_f2, w_f3};

`ifndef INV_KEY_CACHE_EN
    assign w_inv_key = {w_w0 ^ w_sub_out, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};
`endif

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop updates from pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        w_next_state = r_state;
        w_load       = 1'b0;
        w_fwd_step   = 1'b0;
        w_finish     = 1'b0;
`ifdef INV_KEY_CACHE_EN
        w_cache_rd   = 1'b0;
`else
        w_inv_step   = 1'b0;
        w_reload     = 1'b0;
`endif
        if (chg_key) begin
            w_next_state = ST_EXPAND;
            w_load       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_IDLE;
                end
                ST_EXPAND: begin
                    w_fwd_step = 1'b1;
                    if (r_k == PRE_LAST) begin
                        w_finish     = 1'b1;
                        w_next_state = ST_READY;
                    end
                end
                ST_READY: begin
`ifdef INV_KEY_CACHE_EN
                    w_cache_rd = (cur_round <= LAST_ROUND);
`else
                    if (cur_round < r_k) begin
                        w_inv_step = 1'b1;
                    end else if ((cur_round > r_k) && (cur_round <= LAST_ROUND)) begin
                        w_next_state = ST_RELOAD;
                    end
`endif
                end
`ifndef INV_KEY_CACHE_EN
                ST_RELOAD: begin
                    w_reload     = 1'b1;
                    w_next_state = ST_READY;
                end
`endif
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        key_valid = (r_state == ST_READY) && (r_k == cur_round);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k         <= 4'd0;
            r_cur_key   <= '0;
            r_final_key <= '0;
            r_orig_key  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_orig_key <= rx_key;
                r_cur_key  <= rx_key;
                r_k        <= 4'd0;
            end else if (w_fwd_step) begin
                r_cur_key <= w_fwd_key;
                r_k       <= r_k + 4'd1;
                if (w_finish) begin
                    r_final_key <= w_fwd_key;
                end
`ifdef INV_KEY_CACHE_EN
            end else if (w_cache_rd) begin
                r_cur_key <= r_cache[cur_round];
                r_k       <= cur_round;
`else
            end else if (w_inv_step) begin
                r_cur_key <= w_inv_key;
                r_k       <= r_k - 4'd1;
            end else if (w_reload) begin
                r_cur_key <= r_final_key;
                r_k       <= LAST_ROUND;
`endif
            end
        end
    end

`ifdef INV_KEY_CACHE_EN
    // NOTE: the round-key array has no reset; EXPAND rewrites every entry before READY can read one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_load) begin
                r_cache[0] <= rx_key;
            end else if (w_fwd_step) begin
                r_cache[r_k + 4'd1] <= w_fwd_key;
            end
        end
    end
`endif

    assign cur_key         = r_cur_key;
    assign final_key       = r_final_key;
    assign orig_key        = r_orig_key;
    assign change_key_done = r_done;

    k_in_range: assert property (@(posedge clk) disable iff (rst) r_k <= LAST_ROUND);
    done_in_ready: assert property (@(posedge clk) disable iff (rst)
        change_key_done |-> (r_state == ST_READY && r_k == LAST_ROUND));

endmodule

// File: tb/tb_inv_round_key_gen.sv
// Scoreboard bench for inv_round_key_gen: a forward AES-128 key-schedule model predicts every round key.
module tb_inv_round_key_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         chg_key;
    logic [127:0] rx_key;
    logic [3:0]   cur_round;
    logic [127:0] cur_key;
    logic         key_valid;
    logic [127:0] final_key;
    logic [127:0] orig_key;
    logic         change_key_done;

    always #5 clk = ~clk;

    inv_round_key_gen dut (
        .clk             (clk),
        .rst             (rst),
        .chg_key         (chg_key),
        .rx_key          (rx_key),
        .cur_round       (cur_round),
        .cur_key         (cur_key),
        .key_valid       (key_valid),
        .final_key       (final_key),
        .orig_key        (orig_key),
        .change_key_done (change_key_done)
    );

    typedef struct {
        int           rnd;
        logic [127:0] key;
    } key_exp_t;

    typedef struct {
        logic [127:0] fin;
        logic [127:0] orig;
    } done_exp_t;

    key_exp_t     q_key[$];
    done_exp_t    q_done[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [7:0]   sb [256];
    logic [127:0] model_rk [11];
    int           k_model = -1;

    localparam logic [127:0] KEY_HELLO = 128'h68656c6c6f3030303030303030303030;
    localparam logic [127:0] KEY_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expansion with a completion expected exactly 11 edges after chg_key is sampled.
    task automatic load_key(input logic [127:0] key);
        done_exp_t de;
        int        n;
        compute_model(key);
        de.fin  = model_rk[10];
        de.orig = key;
        q_done.push_back(de);
        cur_round = 4'd11;
        rx_key    = key;
        chg_key   = 1'b1;
        tick();
        chg_key = 1'b0;
        n = 1;
        while (!change_key_done && n < 40) begin
            tick();
            n++;
        end
        check("expand_latency", n, 11);
        k_model = 10;
    endtask

    task automatic pulse_only(input logic [127:0] key);
        cur_round = 4'd11;
        rx_key    = key;
        chg_key   = 1'b1;
        tick();
        chg_key = 1'b0;
    endtask

    // Ask for round r; the monitor checks the key, this task checks how many edges it took.
    task automatic request(input int r);
        key_exp_t ke;
        int       n;
        int       exp_lat;
        exp_lat = (r < k_model) ? (k_model - r) : (2 + 10 - r);
        ke.rnd  = r;
        ke.key  = model_rk[r];
        q_key.push_back(ke);
        cur_round = 4'(r);
        n = 0;
        @(negedge clk);
        while (!key_valid && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check($sformatf("latency_to_round%0d", r), n, exp_lat);
        k_model = r;
        tick();
    endtask

    task automatic hold_out_of_range();
        logic [127:0] held;
        held = model_rk[k_model];
        cur_round = 4'd11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("oob_valid_low", key_valid, 0);
            check("oob_key_held", cur_key, held);
            tick();
        end
    endtask

    always @(negedge clk) begin : monitor
        logic      prev_valid;
        logic      prev_done;
        key_exp_t  ke;
        done_exp_t de;
        if (key_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (q_key.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got key %h, expected no response", cur_key);
            end else begin
                ke = q_key.pop_front();
                check($sformatf("round%0d_key", ke.rnd), cur_key, ke.key);
            end
        end
        if (change_key_done === 1'b1) begin
            check("done_pulse_width", prev_done, 0);
            if (q_done.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got final %h, expected no completion", final_key);
            end else begin
                de = q_done.pop_front();
                check("final_key", final_key, de.fin);
                check("orig_key", orig_key, de.orig);
            end
        end
        prev_valid = key_valid;
        prev_done  = change_key_done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        logic [127:0] rk;
        rst       = 1'b1;
        chg_key   = 1'b0;
        rx_key    = '0;
        cur_round = 4'd11;
        build_sbox();
        tick();
        tick();
        check("rst_cur_key", cur_key, 0);
        check("rst_final_key", final_key, 0);
        check("rst_orig_key", orig_key, 0);
        check("rst_key_valid", key_valid, 0);
        check("rst_done", change_key_done, 0);
        rst = 1'b0;
        tick();

        load_key(KEY_HELLO);
        check("hello_final_const", final_key, 128'h0043de6459c9e24b5a4ebb8add080009);
        check("hello_orig_const", orig_key, KEY_HELLO);

        request(9);
        check("hello_round9_const", cur_key, 128'h6ca93273598a3c2f038759c18746bb83);
        check("round9_valid", key_valid, 1);

        for (int i = 8; i >= 0; i--) begin
            request(i);
            if (i == 1) check("hello_round1_const", cur_key, 128'h6d616868025158583261686802515858);
        end
        check("hello_round0_is_key", cur_key, KEY_HELLO);

        request(1);
        request(10);
        check("reload_gives_final", cur_key, 128'h0043de6459c9e24b5a4ebb8add080009);

        request(4);
        hold_out_of_range();

        pulse_only(KEY_HELLO);
        repeat (4) tick();
        load_key(KEY_SEQ);
        check("seq_final_const", final_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        request(5);
        request(0);

        // Reset in the middle of a downward walk clears everything on that edge.
        request(10);
        cur_round = 4'd0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q_key.delete();
        k_model = -1;
        check("midrst_cur_key", cur_key, 0);
        check("midrst_final_key", final_key, 0);
        check("midrst_orig_key", orig_key, 0);
        check("midrst_valid_idle", key_valid, 0);
        check("midrst_done", change_key_done, 0);

        rst     = 1'b1;
        chg_key = 1'b1;
        rx_key  = KEY_SEQ;
        tick();
        rst     = 1'b0;
        chg_key = 1'b0;
        repeat (14) tick();
        check("rst_beats_chg_orig", orig_key, 0);
        check("rst_beats_chg_cur", cur_key, 0);

        for (int t = 0; t < 4; t++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                pulse_only({$urandom, $urandom, $urandom, $urandom});
                repeat ($urandom_range(0, 9)) tick();
            end
            load_key(rk);
            for (int j = 0; j < 15; j++) begin
                if ($urandom_range(0, 4) == 0) begin
                    hold_out_of_range();
                end else begin
                    r = int'($urandom_range(0, 10));
                    if (r == k_model) r = (r + 1) % 11;
                    request(r);
                end
            end
        end

        repeat (3) tick();
        check("key_queue_drained", q_key.size(), 0);
        check("done_queue_drained", q_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
